// File: rtl/sha256d_pkg.sv
// rtl/sha256d_pkg.sv - shared constants, FSM encoding and byte-swap helper for the nonce sequencer
// Purpose: header geometry (20 big-endian words, nonce in word 19), sequencer
//          state encoding and a 32-bit byte-swap function.
package sha256d_pkg;

    localparam int HDR_WORDS  = 20;
    localparam int NONCE_WORD = 19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/hash_target_cmp.sv
// rtl/hash_target_cmp.sv - registered little-endian hash <= target comparator
// Purpose: interprets the digest as a Bitcoin little-endian uint256 (byte
//          reversal) and registers value <= target when en is high.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          capture strobe (the cycle the done edge is seen)
//   hash        256-bit digest, byte 0 in bits [255:248]
//   target      256-bit unsigned target
//   hit         registered compare result, valid the cycle after en
module hash_target_cmp (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [255:0] hash,
    input  logic [255:0] target,
    output logic         hit
);

    logic [255:0] value;
    logic         hit_d;
    logic         hit_q;

    always_comb begin
        value = '0;
        for (int i = 0; i < 32; i++) begin
            value[8*i +: 8] = hash[8*(31-i) +: 8];
        end
    end

    always_comb begin
        hit_d = hit_q;
        if (en) begin
            hit_d = (value <= target);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit = hit_q;

endmodule

// File: rtl/nonce_sequencer.sv
// rtl/nonce_sequencer.sv - mining control stage around sha256d_wrapper
// Purpose: holds the 80-byte header, serves the wrapper's word-read bus with
//          the live nonce in word 19, checks each digest against the target
//          and steps the nonce or reports a hit / exhausted range.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   hdr_we/hdr_waddr/hdr_wdata    header word write (IDLE only)
//   target/nonce_start/nonce_end  search parameters, sampled on go
//   go, stop                      start search, abort request
//   hw_start                      one-cycle start pulse to the wrapper
//   hw_addr/hw_rq/hw_data/hw_rdy  wrapper word-read bus
//   hw_hash/hw_done               wrapper digest and completion level
//   busy/found/found_nonce/exhausted/nonce_cur  status
// Configuration: HASH_COUNT_EN adds hash_count[31:0], a saturating count of
//                completed checks, cleared by reset only.
module nonce_sequencer
    import sha256d_pkg::*;
#(
    parameter logic [31:0] NONCE_STEP = 32'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hdr_we,
    input  logic [4:0]   hdr_waddr,
    input  logic [31:0]  hdr_wdata,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic         go,
    input  logic         stop,
    output logic         hw_start,
    input  logic [4:0]   hw_addr,
    input  logic         hw_rq,
    output logic [31:0]  hw_data,
    output logic         hw_rdy,
    input  logic [255:0] hw_hash,
    input  logic         hw_done,
    output logic         busy,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic         exhausted,
`ifdef HASH_COUNT_EN
    output logic [31:0]  hash_count,
`endif
    output logic [31:0]  nonce_cur
);

    state_t        state_d, state_q;
    logic [31:0]   hdr_d [HDR_WORDS];
    logic [31:0]   hdr_q [HDR_WORDS];
    logic [255:0]  target_d, target_q;
    logic [31:0]   nonce_cur_d, nonce_cur_q;
    logic [31:0]   nonce_end_d, nonce_end_q;
    logic          found_d, found_q;
    logic [31:0]   found_nonce_d, found_nonce_q;
    logic          exhausted_d, exhausted_q;
    logic          stop_pend_d, stop_pend_q;
    logic          done_d, done_q;
    logic          rdy_d, rdy_q;
    logic [31:0]   data_d, data_q;
    logic [31:0]   rd_word;
    logic          done_edge;
    logic          stop_eff;
    logic          cmp_hit;
`ifdef HASH_COUNT_EN
    logic [31:0]   hash_count_d, hash_count_q;
`endif

    hash_target_cmp u_cmp (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (done_edge && (state_q == ST_WAIT)),
        .hash   (hw_hash),
        .target (target_q),
        .hit    (cmp_hit)
    );

    // Word-read bus: the nonce register overrides header word 19, addresses
    // past the header read as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < HDR_WORDS; i++) begin
            if (hw_addr == 5'(i)) rd_word = hdr_q[i];
        end
        if (hw_addr == 5'(NONCE_WORD)) rd_word = bswap32(nonce_cur_q);
        rdy_d  = hw_rq;
        data_d = hw_rq ? rd_word : '0;
    end

    always_comb begin
        done_d        = hw_done;
        done_edge     = hw_done && !done_q;
        // A stop arriving in the CHECK cycle itself still ends the run there.
        stop_eff      = stop_pend_q || stop;
        state_d       = state_q;
        hdr_d         = hdr_q;
        target_d      = target_q;
        nonce_cur_d   = nonce_cur_q;
        nonce_end_d   = nonce_end_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        exhausted_d   = exhausted_q;
        stop_pend_d   = (state_q == ST_IDLE) ? 1'b0 : stop_eff;
        hw_start      = 1'b0;
`ifdef HASH_COUNT_EN
        hash_count_d  = hash_count_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Write before go so a same-cycle header update is seen by START.
                for (int i = 0; i < HDR_WORDS; i++) begin
                    if (hdr_we && (hdr_waddr == 5'(i))) hdr_d[i] = hdr_wdata;
                end
                if (go) begin
                    state_d       = ST_START;
                    target_d      = target;
                    nonce_cur_d   = nonce_start;
                    nonce_end_d   = nonce_end;
                    found_d       = 1'b0;
                    found_nonce_d = '0;
                    exhausted_d   = 1'b0;
                    stop_pend_d   = 1'b0;
                end
            end
            ST_START: begin
                hw_start = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_edge) state_d = ST_CHECK;
            end
            ST_CHECK: begin
`ifdef HASH_COUNT_EN
                if (hash_count_q != 32'hFFFF_FFFF) hash_count_d = hash_count_q + 32'd1;
`endif
                if (cmp_hit) begin
                    state_d       = ST_IDLE;
                    found_d       = 1'b1;
                    found_nonce_d = nonce_cur_q;
                    stop_pend_d   = 1'b0;
                end else if ((nonce_cur_q == nonce_end_q) || stop_eff) begin
                    state_d     = ST_IDLE;
                    exhausted_d = !stop_eff;
                    stop_pend_d = 1'b0;
                end else begin
                    nonce_cur_d = nonce_cur_q + NONCE_STEP;
                    state_d     = ST_START;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            for (int i = 0; i < HDR_WORDS; i++) hdr_q[i] <= '0;
            target_q      <= '0;
            nonce_cur_q   <= '0;
            nonce_end_q   <= '0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            exhausted_q   <= 1'b0;
            stop_pend_q   <= 1'b0;
            done_q        <= 1'b0;
            rdy_q         <= 1'b0;
            data_q        <= '0;
`ifdef HASH_COUNT_EN
            hash_count_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            hdr_q         <= hdr_d;
            target_q      <= target_d;
            nonce_cur_q   <= nonce_cur_d;
            nonce_end_q   <= nonce_end_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            exhausted_q   <= exhausted_d;
            stop_pend_q   <= stop_pend_d;
            done_q        <= done_d;
            rdy_q         <= rdy_d;
            data_q        <= data_d;
`ifdef HASH_COUNT_EN
            hash_count_q  <= hash_count_d;
`endif
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign exhausted   = exhausted_q;
    assign nonce_cur   = nonce_cur_q;
    assign hw_rdy      = rdy_q;
    assign hw_data     = data_q;
`ifdef HASH_COUNT_EN
    assign hash_count  = hash_count_q;
`endif

endmodule

// File: tb/tb_nonce_sequencer.sv
// tb/tb_nonce_sequencer.sv - self-checking bench for nonce_sequencer with a behavioural wrapper model
module tb_nonce_sequencer;
    import sha256d_pkg::*;

    localparam logic [31:0]  HIT_NONCE = 32'h7C2BAC1D;
    localparam logic [255:0] GEN_HASH  =
        256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
    localparam logic [255:0] GEN_VALUE =
        256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         hdr_we = 1'b0;
    logic [4:0]   hdr_waddr = '0;
    logic [31:0]  hdr_wdata = '0;
    logic [255:0] target = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic         go = 1'b0;
    logic         stop = 1'b0;
    logic         hw_start;
    logic [4:0]   hw_addr;
    logic         hw_rq;
    logic [31:0]  hw_data;
    logic         hw_rdy;
    logic [255:0] hw_hash = '0;
    logic         hw_done = 1'b0;
    logic         busy;
    logic         found;
    logic [31:0]  found_nonce;
    logic         exhausted;
    logic [31:0]  nonce_cur;
`ifdef HASH_COUNT_EN
    logic [31:0]  hash_count;
`endif

    // Bus driven by the wrapper model when enabled, else by the main sequence.
    logic         model_en = 1'b0;
    logic         m_rq = 1'b0, t_rq = 1'b0;
    logic [4:0]   m_addr = '0, t_addr = '0;
    assign hw_rq   = model_en ? m_rq : t_rq;
    assign hw_addr = model_en ? m_addr : t_addr;

    nonce_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .hdr_we(hdr_we), .hdr_waddr(hdr_waddr), .hdr_wdata(hdr_wdata),
        .target(target), .nonce_start(nonce_start), .nonce_end(nonce_end),
        .go(go), .stop(stop), .hw_start(hw_start),
        .hw_addr(hw_addr), .hw_rq(hw_rq), .hw_data(hw_data), .hw_rdy(hw_rdy),
        .hw_hash(hw_hash), .hw_done(hw_done),
        .busy(busy), .found(found), .found_nonce(found_nonce), .exhausted(exhausted),
`ifdef HASH_COUNT_EN
        .hash_count(hash_count),
`endif
        .nonce_cur(nonce_cur)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Genesis block header as 20 big-endian words.
    logic [31:0] genesis [20];
    initial begin
        genesis = '{32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
                    32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d,
                    32'h1dac2b7c};
    end

    // Wrapper model state
    logic [31:0] exp_nonce = '0;
    logic [31:0] exp_hdr0  = '0;
    logic [31:0] cur;
    int          n_starts = 0;
    int          go_cyc = 0;
    int          done_cyc = 0;

    // Wrapper model: on each start pulse, read nonce word and two header
    // words, then raise done with a digest that hits only at HIT_NONCE.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (model_en && hw_start) begin
                if (n_starts == 0) chk("start_latency_go", cyc, go_cyc + 1);
                else               chk("start_latency_done", cyc, done_cyc + 2);
                cur = exp_nonce + 32'(n_starts);
                n_starts++;
                hw_done = 1'b0;
                m_rq = 1'b1; m_addr = 5'd19;
                @(posedge clk); #1;
                chk("start_pulse_width", hw_start, 1'b0);
                chk("rdy_word19", hw_rdy, 1'b1);
                chk("data_word19", hw_data, bswap32(cur));
                m_addr = 5'd9;
                @(posedge clk); #1;
                chk("data_word9", hw_data, 32'h3ba3edfd);
                m_addr = 5'd0;
                @(posedge clk); #1;
                chk("data_word0", hw_data, exp_hdr0);
                m_rq = 1'b0; m_addr = 5'd21;
                @(posedge clk); #1;
                chk("rdy_drop", hw_rdy, 1'b0);
                @(posedge clk); #1;
                hw_hash  = (cur == HIT_NONCE) ? GEN_HASH : '1;
                hw_done  = 1'b1;
                done_cyc = cyc;
            end
        end
    end

    typedef struct {
        logic [31:0]  ns;
        logic [31:0]  ne;
        logic [255:0] tgt;
        logic [31:0]  w0;
        bit           do_stop;
        bit           exp_found;
        logic [31:0]  exp_fn;
        bit           exp_exh;
        int           exp_hashes;
        logic [31:0]  exp_cur;
    } vec_t;

    vec_t vecs[7];
    int   exp_count = 0;

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        nonce_start = v.ns; nonce_end = v.ne; target = v.tgt;
        exp_nonce = v.ns; n_starts = 0; exp_hdr0 = v.w0;
        hdr_we = 1'b1; hdr_waddr = 5'd0; hdr_wdata = v.w0;
        go = 1'b1; go_cyc = cyc;
        @(negedge clk);
        // go and header write while busy must both be ignored
        nonce_start = 32'hAAAAAAAA; hdr_wdata = 32'hDEADBEEF;
        chk($sformatf("v%0d_busy", idx), busy, 1'b1);
        @(negedge clk);
        go = 1'b0; hdr_we = 1'b0; nonce_start = v.ns;
        if (v.do_stop) begin
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
        end
        for (int i = 0; i < 600 && busy; i++) @(negedge clk);
        chk($sformatf("v%0d_timeout_busy", idx), busy, 1'b0);
        chk($sformatf("v%0d_idle_latency", idx), cyc, done_cyc + 2);
        chk($sformatf("v%0d_found", idx), found, v.exp_found);
        if (v.exp_found) chk($sformatf("v%0d_found_nonce", idx), found_nonce, v.exp_fn);
        chk($sformatf("v%0d_exhausted", idx), exhausted, v.exp_exh);
        chk($sformatf("v%0d_hashes", idx), n_starts, v.exp_hashes);
        chk($sformatf("v%0d_nonce_cur", idx), nonce_cur, v.exp_cur);
        exp_count += v.exp_hashes;
`ifdef HASH_COUNT_EN
        chk($sformatf("v%0d_hash_count", idx), hash_count, exp_count);
`endif
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_hw_start"}, hw_start, 1'b0);
        chk({tag, "_found"}, found, 1'b0);
        chk({tag, "_found_nonce"}, found_nonce, 32'h0);
        chk({tag, "_exhausted"}, exhausted, 1'b0);
        chk({tag, "_nonce_cur"}, nonce_cur, 32'h0);
        chk({tag, "_hw_rdy"}, hw_rdy, 1'b0);
        chk({tag, "_hw_data"}, hw_data, 32'h0);
`ifdef HASH_COUNT_EN
        chk({tag, "_hash_count"}, hash_count, 32'h0);
`endif
    endtask

    initial begin
        vecs[0] = '{32'd10, 32'd14, 256'd0, 32'h01000000, 1'b0, 1'b0, 32'd0, 1'b1, 5, 32'd14};
        vecs[1] = '{32'h7C2BAC1B, 32'h7C2BAC1F, {32'h0, 32'hFFFF0000, 192'h0}, 32'h01000000,
                    1'b0, 1'b1, HIT_NONCE, 1'b0, 3, HIT_NONCE};
        vecs[2] = '{32'h0, 32'h0, 256'd0, 32'h00000002, 1'b0, 1'b0, 32'd0, 1'b1, 1, 32'h0};
        vecs[3] = '{HIT_NONCE, HIT_NONCE, GEN_VALUE, 32'h01000000, 1'b0, 1'b1, HIT_NONCE, 1'b0, 1, HIT_NONCE};
        vecs[4] = '{HIT_NONCE, HIT_NONCE, GEN_VALUE - 256'd1, 32'h01000000, 1'b0, 1'b0, 32'd0, 1'b1, 1, HIT_NONCE};
        vecs[5] = '{32'hFFFFFFFE, 32'h00000001, 256'd0, 32'h01000000, 1'b0, 1'b0, 32'd0, 1'b1, 4, 32'h1};
        vecs[6] = '{32'd0, 32'd100, 256'd0, 32'h01000000, 1'b1, 1'b0, 32'd0, 1'b0, 1, 32'h0};

        #12;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Bus check in WAIT with the wrapper model disconnected, then async reset.
        @(negedge clk);
        nonce_start = 32'h12345678; nonce_end = 32'h12345690; target = '0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        chk("bus_busy", busy, 1'b1);
        chk("bus_nonce_cur", nonce_cur, 32'h12345678);
        t_rq = 1'b1; t_addr = 5'd19;
        @(negedge clk);
        chk("bus_rdy_19", hw_rdy, 1'b1);
        chk("bus_data_19", hw_data, 32'h78563412);
        t_addr = 5'd21;
        @(negedge clk);
        chk("bus_rdy_21", hw_rdy, 1'b1);
        chk("bus_data_21", hw_data, 32'h0);
        t_rq = 1'b0;
        @(negedge clk);
        chk("bus_rdy_drop", hw_rdy, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reload the header (reset cleared it); word 0 is rewritten with each go.
        for (int i = 0; i < HDR_WORDS; i++) begin
            @(negedge clk);
            hdr_we = 1'b1; hdr_waddr = 5'(i); hdr_wdata = genesis[i];
        end
        @(negedge clk);
        hdr_we = 1'b0;
        model_en = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // stop while IDLE is ignored: next run still completes normally
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_idle_busy", busy, 1'b0);
        run_vec(7, vecs[2]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
